// File: rtl/sd_frame_packer_if.sv
// sd_frame_packer_if
//   Bundles the control, byte-stream and frame-write signals of sd_frame_packer.
//   master  : the packer side (drives byte_ready, the write port and status).
//   slave   : the environment side (drives start/abort, the byte source and write_req_ack).
//   Signals:
//     start, abort                 control pulses
//     byte_valid/byte_data/byte_ready  8-bit source stream
//     write_req/write_req_ack      frame write handshake
//     write_addr_index             buffer being written
//     write_en/write_data          word push
//     busy, frame_done, aborted, last_index, err_drop  status
interface sd_frame_packer_if #(
  parameter int DATA_BITS = 32
) ();
  logic                 start;
  logic                 abort;
  logic                 byte_valid;
  logic [7:0]           byte_data;
  logic                 byte_ready;
  logic                 write_req;
  logic                 write_req_ack;
  logic [1:0]           write_addr_index;
  logic                 write_en;
  logic [DATA_BITS-1:0] write_data;
  logic                 busy;
  logic                 frame_done;
  logic                 aborted;
  logic [1:0]           last_index;
  logic                 err_drop;

  modport master (
    input  start, abort, byte_valid, byte_data, write_req_ack,
    output byte_ready, write_req, write_addr_index, write_en, write_data,
           busy, frame_done, aborted, last_index, err_drop
  );

  modport slave (
    output start, abort, byte_valid, byte_data, write_req_ack,
    input  byte_ready, write_req, write_addr_index, write_en, write_data,
           busy, frame_done, aborted, last_index, err_drop
  );
endinterface

// File: rtl/sd_frame_packer.sv
// sd_frame_packer
//   Packs an 8-bit byte stream into DATA_BITS-wide words and writes one frame of
//   FRAME_WORDS words per start, rotating through NUM_BUFS frame buffers.
//   Ports:
//     clk    single clock
//     rst_n  asynchronous active-low reset
//     bus    sd_frame_packer_if.master (control, byte stream, write port, status)
module sd_frame_packer #(
  parameter int DATA_BITS   = 32,
  parameter int FRAME_WORDS = 307200,
  parameter int NUM_BUFS    = 2,
  parameter int LSB_FIRST   = 1,
  parameter int LEN_BITS    = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  sd_frame_packer_if.master  bus
);
  localparam int BPW   = DATA_BITS / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     byte_cnt;
  logic [LEN_BITS-1:0]  word_cnt;
  logic [BPW-1:0][7:0]  lane_q, word_nxt;
  logic [1:0]           idx_q, last_q;
  logic                 we_q, aborted_q, err_q, busy_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 in_frame, accept, last_byte, last_word;

  assign in_frame  = (state_q == REQ) || (state_q == FILL);
  // abort outranks a byte arriving in the same cycle, including the final one
  assign accept    = (state_q == FILL) && bus.byte_valid && !bus.abort;
  assign last_byte = byte_cnt == CNT_W'(BPW - 1);
  assign last_word = word_cnt == LEN_BITS'(FRAME_WORDS - 1);

  // Current word with the incoming byte merged into the lane its count maps to;
  // used both to update the lane store and as the pushed word on the last byte.
  always_comb begin
    word_nxt = lane_q;
    for (int g = 0; g < BPW; g++) begin
      if (byte_cnt == CNT_W'((LSB_FIRST != 0) ? g : (BPW - 1 - g)))
        word_nxt[g] = bus.byte_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = REQ;
      REQ: begin
        if (bus.abort)              state_d = IDLE;
        else if (bus.write_req_ack) state_d = FILL;
      end
      FILL: begin
        if (bus.abort)                             state_d = IDLE;
        else if (accept && last_byte && last_word) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      lane_q    <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      we_q      <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= state_d != IDLE;
      we_q      <= 1'b0;
      aborted_q <= in_frame && bus.abort;

      if (state_q == IDLE && bus.start) begin
        byte_cnt <= '0;
        word_cnt <= '0;
        err_q    <= 1'b0;
      end

      // REQ never asserts byte_ready, so any offered byte is a drop
      if (state_q == REQ && bus.byte_valid) err_q <= 1'b1;

      if (in_frame && bus.abort) byte_cnt <= '0;

      if (accept) begin
        lane_q <= word_nxt;
        if (last_byte) begin
          byte_cnt <= '0;
          word_cnt <= word_cnt + LEN_BITS'(1);
          data_q   <= word_nxt;
          we_q     <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + CNT_W'(1);
        end
      end

      if (state_q == DONE) begin
        last_q <= idx_q;
        idx_q  <= (idx_q == 2'(NUM_BUFS - 1)) ? 2'd0 : idx_q + 2'd1;
      end
    end
  end

  assign bus.byte_ready       = state_q == FILL;
  assign bus.write_req        = state_q == REQ;
  assign bus.write_addr_index = idx_q;
  assign bus.write_en         = we_q;
  assign bus.write_data       = data_q;
  assign bus.busy             = busy_q;
  assign bus.frame_done       = state_q == DONE;
  assign bus.aborted          = aborted_q;
  assign bus.last_index       = last_q;
  assign bus.err_drop         = err_q;
endmodule

// File: tb/tb_sd_frame_packer.sv
// tb_sd_frame_packer
//   Drives two packers (LSB-first and MSB-first) from one stimulus stream.
//   Expected words are queued as bytes are driven and popped when write_en fires.
module tb_sd_frame_packer;
  localparam int DB = 32;
  localparam int FW = 4;
  localparam int NB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sd_frame_packer_if #(.DATA_BITS(DB)) bus ();
  sd_frame_packer_if #(.DATA_BITS(DB)) bus_m ();

  sd_frame_packer #(.DATA_BITS(DB), .FRAME_WORDS(FW), .NUM_BUFS(NB), .LSB_FIRST(1), .LEN_BITS(24))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  sd_frame_packer #(.DATA_BITS(DB), .FRAME_WORDS(FW), .NUM_BUFS(NB), .LSB_FIRST(0), .LEN_BITS(24))
    dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m.master));

  assign bus_m.start         = bus.start;
  assign bus_m.abort         = bus.abort;
  assign bus_m.byte_valid    = bus.byte_valid;
  assign bus_m.byte_data     = bus.byte_data;
  assign bus_m.write_req_ack = bus.write_req_ack;

  typedef struct {
    logic [31:0] wl;
    logic [31:0] wm;
    logic        last;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int passed = 0;
  logic [31:0] ml, mm;
  int mk, mw;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    ml[8*mk +: 8]     = b;
    mm[8*(3-mk) +: 8] = b;
    if (mk == 3) begin
      q.push_back('{wl: ml, wm: mm, last: (mw == FW - 1)});
      mk = 0;
      mw++;
    end else begin
      mk++;
    end
    step();
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_start(input int exp_idx);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    mk = 0;
    mw = 0;
    chk("req_after_start", bus.write_req, 1);
    chk("idx_at_start", bus.write_addr_index, exp_idx);
    bus.write_req_ack = 1'b1;
    step();
    bus.write_req_ack = 1'b0;
    chk("ready_after_ack", bus.byte_ready, 1);
    chk("req_drop", bus.write_req, 0);
  endtask

  task automatic run_frame(input int exp_idx, input logic [7:0] base);
    do_start(exp_idx);
    for (int i = 0; i < 16; i++) send(base + 8'(i));
    chk("done_pulse", bus.frame_done, 1);
    chk("ready_low_final", bus.byte_ready, 0);
    step();
    chk("last_index", bus.last_index, exp_idx);
    chk("next_idx", bus.write_addr_index, (exp_idx + 1) % NB);
    chk("idle_after_done", bus.busy, 0);
    chk("done_one_cycle", bus.frame_done, 0);
  endtask

  // Scoreboard: every push must match the queued word; frame_done only with the last push
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.write_en) begin
        if (q.size() == 0) chk("unexpected_push", bus.write_en, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("word_lsb", bus.write_data, e.wl);
          chk("word_msb", bus_m.write_data, e.wm);
          chk("msb_push_align", bus_m.write_en, 1);
          chk("done_with_push", bus.frame_done, e.last);
        end
      end else if (bus.frame_done) begin
        chk("stray_done", bus.frame_done, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.abort = 0; bus.byte_valid = 0; bus.byte_data = 0; bus.write_req_ack = 0;
    ml = 0; mm = 0; mk = 0; mw = 0;

    // reset with random inputs
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'($urandom); bus.abort = 1'($urandom); bus.byte_valid = 1'($urandom);
      bus.byte_data = 8'($urandom); bus.write_req_ack = 1'($urandom);
      step();
    end
    chk("rst_write_req", bus.write_req, 0);
    chk("rst_byte_ready", bus.byte_ready, 0);
    chk("rst_write_en", bus.write_en, 0);
    chk("rst_write_data", bus.write_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_aborted", bus.aborted, 0);
    chk("rst_idx", bus.write_addr_index, 0);
    chk("rst_last", bus.last_index, 0);
    chk("rst_err_drop", bus.err_drop, 0);
    bus.start = 0; bus.abort = 0; bus.byte_valid = 0; bus.byte_data = 0; bus.write_req_ack = 0;
    rst_n = 1'b1;
    step();
    chk("idle_ready_low", bus.byte_ready, 0);
    chk("idle_not_busy", bus.busy, 0);

    // frame 0: ack held off while the source offers bytes
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    mk = 0; mw = 0;
    chk("req_after_start", bus.write_req, 1);
    chk("idx_at_start", bus.write_addr_index, 0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("req_held", bus.write_req, 1);
      chk("req_no_ready", bus.byte_ready, 0);
    end
    bus.write_req_ack = 1'b1;
    step();
    bus.write_req_ack = 1'b0;
    bus.byte_valid = 1'b0;
    chk("req_drop", bus.write_req, 0);
    chk("ready_after_ack", bus.byte_ready, 1);
    chk("err_drop_set", bus.err_drop, 1);
    for (int i = 0; i < 16; i++) begin
      send(8'(i + 1));
      if (i == 3) begin
        chk("first_word_lsb", bus.write_data, 32'h04030201);
        chk("first_word_msb", bus_m.write_data, 32'h01020304);
      end
    end
    chk("done_pulse", bus.frame_done, 1);
    chk("ready_low_final", bus.byte_ready, 0);
    step();
    chk("data_holds", bus.write_data, 32'h100F0E0D);
    chk("last_index", bus.last_index, 0);
    chk("next_idx", bus.write_addr_index, 1);
    chk("err_drop_sticky", bus.err_drop, 1);

    // buffer rotation
    run_frame(1, 8'h20);
    chk("err_drop_cleared", bus.err_drop, 0);
    run_frame(2, 8'h40);
    run_frame(0, 8'h60);

    // start ignored mid-FILL, then reset mid-FILL
    do_start(1);
    for (int i = 0; i < 5; i++) send(8'h80 + 8'(i));
    bus.start = 1'b1;
    send(8'h85);
    bus.start = 1'b0;
    chk("start_ign_busy", bus.busy, 1);
    chk("start_ign_req", bus.write_req, 0);
    chk("start_ign_ready", bus.byte_ready, 1);
    for (int i = 6; i < 10; i++) send(8'h80 + 8'(i));
    rst_n = 1'b0;
    #1;
    chk("midrst_idx", bus.write_addr_index, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ready", bus.byte_ready, 0);
    chk("midrst_data", bus.write_data, 0);
    bus.byte_valid = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    bus.byte_valid = 1'b0;
    step();
    chk("midrst_q_empty", q.size(), 0);

    // abort after 6 bytes
    do_start(0);
    for (int i = 0; i < 6; i++) send(8'hC0 + 8'(i));
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_pulse", bus.aborted, 1);
    chk("abort_idle", bus.busy, 0);
    chk("abort_ready", bus.byte_ready, 0);
    step();
    chk("abort_one_cycle", bus.aborted, 0);
    chk("abort_idx", bus.write_addr_index, 0);
    chk("abort_last", bus.last_index, 0);

    // next frame packs from lane 0
    run_frame(0, 8'hA0);

    // abort coincident with the final byte
    do_start(1);
    for (int i = 0; i < 15; i++) send(8'hD0 + 8'(i));
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hFF;
    bus.abort      = 1'b1;
    step();
    bus.byte_valid = 1'b0;
    bus.abort      = 1'b0;
    chk("abort_final_pulse", bus.aborted, 1);
    chk("abort_final_no_we", bus.write_en, 0);
    chk("abort_final_no_done", bus.frame_done, 0);
    step();
    chk("abort_final_idx", bus.write_addr_index, 1);
    chk("abort_final_last", bus.last_index, 0);

    // abort in IDLE ignored
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_idle_ign", bus.aborted, 0);

    step();
    chk("final_q_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sd_frame_packer.md
# sd_frame_packer

Parametrised byte-to-word frame packer between the SD-card BMP reader (8-bit byte stream, `sd_card_clk` domain) and the write port of `frame_read_write`. It runs the write_req/write_req_ack frame handshake and packs bytes into `DATA_BITS`-wide words, pushed with `write_en`/`write_data`. It rotates through up to four frame buffers via `write_addr_index`, so the next image can load while the previous one is displayed. It replaces the fixed single-buffer, fixed-length hookup.

## Interface
- `DATA_BITS`, 32, output word width; multiple of 8, range 8..64
- `FRAME_WORDS`, 307200, words per frame; must be ≥1
- `NUM_BUFS`, 2, frame buffers in rotation, 1..4
- `LSB_FIRST`, 1, 1: first byte of a word goes to `[7:0]`; 0: first byte goes to the MSB byte
- `LEN_BITS`, 24, width of the word counter; must satisfy FRAME_WORDS < 2^LEN_BITS

Ports:
- `clk`  in  1  single clock (sd_card_clk)
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse: begin capture of one frame
- `abort`  in  1  pulse: cancel the current frame
- `byte_valid`  in  1  source byte valid
- `byte_data`  in  8  source byte
- `byte_ready`  out  1  byte accepted when `byte_valid && byte_ready`
- `write_req`  out  1  frame write request to frame_read_write
- `write_req_ack`  in  1  request acknowledge
- `write_addr_index`  out  2  buffer index being written
- `write_en`  out  1  one-cycle word push
- `write_data`  out  DATA_BITS  packed word
- `busy`  out  1  state ≠ IDLE
- `frame_done`  out  1  one-cycle pulse: full frame written
- `aborted`  out  1  one-cycle pulse: frame cancelled
- `last_index`  out  2  index of the most recently completed frame
- `err_drop`  out  1  sticky: `byte_valid` seen while `byte_ready` is low in REQ; cleared by `start`

## Operation
- The block defines BPW = DATA_BITS/8. Internal byte counter: ceil(log2 BPW) bits. Word counter: LEN_BITS bits.
- States: IDLE, REQ, FILL, DONE.
- **IDLE**: `byte_ready`=0. On `start`: clear the counters, clear `err_drop`, and go to REQ.
- **REQ**: `write_req`=1. On `write_req_ack`=1, go to FILL. `write_req` is 0 in every other state.
- **FILL**: `byte_ready`=1.
  - Each accepted byte is placed in byte lane k, where k is the byte count. With LSB_FIRST=1 that is bits [8k+7:8k]; with LSB_FIRST=0 it is lane BPW-1-k.
  - When the BPW-th byte is accepted, the assembled word is registered to `write_data`, `write_en` pulses, the byte counter wraps to 0, and the word counter increments.
  - When the word counter reaches FRAME_WORDS, go to DONE. `byte_ready` drops in the same cycle that `write_en` pulses for the final word.
- **DONE**: one cycle.
  - `frame_done`=1.
  - `last_index` ← `write_addr_index`.
  - `write_addr_index` ← `write_addr_index`+1, wrapping to 0 at NUM_BUFS.
  - Go to IDLE.
- **abort**, in REQ or FILL: go to IDLE next cycle and pulse `aborted`.
  - Any partial word is discarded and no `write_en` is issued for it.
  - Index and `last_index` are unchanged.
  - `abort` in IDLE or DONE is ignored; DONE completes normally.
  - If `abort` and the final byte arrive in the same cycle, abort wins: no `write_en` and no `frame_done`.
- `start` outside IDLE is ignored.
- With NUM_BUFS=1, `write_addr_index` stays 0.
- `write_data` holds its value between pushes.

## Timing
- Reset values: all outputs 0; state IDLE; index 0.
- `start` at cycle t → `write_req`=1 at t+1.
- `write_req_ack` sampled high at cycle a → `write_req`=0 and `byte_ready`=1 at a+1.
- Word-completing byte accepted at cycle t → `write_en`/`write_data` valid at t+1.
- Final byte at cycle t:
  - `write_en` and `frame_done` at t+1 (state DONE).
  - Updated index and `last_index` at t+2 (IDLE).
- `busy` is registered and follows the state.
- Sustained throughput: one byte per cycle in FILL, no bubbles at word boundaries.
- Reset asserted mid-frame: immediate return to reset values, with no `write_en` or `frame_done`.

## Test plan
Bench parameters: DATA_BITS=32, FRAME_WORDS=4, NUM_BUFS=3.
- Reset with random inputs driven → all outputs 0; `byte_ready`=0 while in IDLE.
- `start`, then `write_req_ack` delayed 5 cycles while `byte_valid`=1 → `write_req` held high 5 cycles; no byte accepted; `err_drop`=1; `write_req`=0 the cycle after ack.
- Bytes 0x01..0x10 back-to-back → `write_en` 4 times with words 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D. `frame_done` coincides with the 4th push. With LSB_FIRST=0 the first word is 0x01020304.
- Four consecutive frames → `write_addr_index` 0,1,2,0 at each `start`; `last_index` after each frame 0,1,2,0.
- `abort` after 6 bytes of frame 0 → one push only, `aborted` pulses, no `frame_done`, index stays 0. The next frame packs fresh from lane 0.
- `start` pulsed mid-FILL → ignored. `rst_n` low mid-FILL → immediate reset values, and the frame restarts at index 0.
